ceas_alarma: RTL and testbench
==============================

# ceas_alarma

- Receiving end of the time/alarm setting path.
- Accepts the `ore`/`minute` value and the one-cycle `load_timp` / `load_alarma` pulses produced by the setting block, then keeps running time HH:MM:SS from a 1 Hz enable.
- Holds the alarm time and runs the alarm state machine that drives the ringing output.
- Sits between the setting block and the display/buzzer logic.

## Interface
Parameters:
- `RING_SECONDS`, 60: ticks the alarm rings before auto-stop (1..255).
- `SNOOZE_MIN`, 5: snooze length in minutes (1..15); used only with `SNOOZE_EN`.

Ports:
- `clock` input 1: system clock; all state updates on posedge.
- `reset` input 1: reset, synchronous, active-high.
- `tick_sec` input 1: 1-cycle pulse, once per second.
- `ore_in` input 5: hours from setting block.
- `minute_in` input 6: minutes from setting block.
- `load_timp` input 1: 1-cycle pulse, load current time.
- `load_alarma` input 1: 1-cycle pulse, load alarm time and arm.
- `alarm_off` input 1: pulse, stop ringing and stay armed.
- `alarm_dis` input 1: pulse, disarm.
- `snooze` input 1: pulse, snooze (`SNOOZE_EN` only).
- `ore` output 5: current hours, 0..23.
- `minute` output 6: current minutes, 0..59.
- `secunde` output 6: current seconds, 0..59.
- `alarm_ore` output 5: stored alarm hours.
- `alarm_min` output 6: stored alarm minutes.
- `alarm_armed` output 1: state is ARMED, RINGING or SNOOZE.
- `alarm_ring` output 1: state is RINGING.
- `load_err` output 1: 1-cycle pulse, rejected out-of-range load.

## Operation
- Reset:
  - All outputs and counters are 0; state is DISARMED.
- Time counter:
  - On `tick_sec`, `secunde` increments.
  - 59→0 carries into `minute`; `minute` 59→0 carries into `ore`; `ore` 23→0.
  - 23:59:59 + tick = 00:00:00.
- `load_timp`:
  - If `ore_in`≤23 and `minute_in`≤59: `ore`/`minute` are loaded and `secunde`=0.
  - Otherwise the time is unchanged and `load_err` pulses.
- `load_alarma`:
  - If the value is in range: `alarm_ore`/`alarm_min` are loaded, ring/snooze counters clear, and state goes to ARMED from any state.
  - If out of range: registers and state are unchanged and `load_err` pulses.
- Trigger:
  - In ARMED, a `tick_sec` whose result has `secunde`=0 and HH:MM equal to the alarm time moves the state to RINGING and clears the ring counter.
  - Loading the time equal to the alarm time never triggers; only a tick rollover triggers.
- States and transitions:
  - DISARMED: moves only on `load_alarma`.
  - ARMED: trigger → RINGING.
  - RINGING:
    - Each tick increments the ring counter.
    - When the counter reaches `RING_SECONDS` → ARMED.
    - `alarm_off` → ARMED.
    - `snooze` → SNOOZE (`SNOOZE_EN` only).
  - SNOOZE:
    - Each tick decrements the snooze counter, which was loaded with `SNOOZE_MIN`*60.
    - At 0 → RINGING, with the ring counter cleared.
    - `alarm_off` → ARMED.
  - Any state: `alarm_dis` → DISARMED.
- Priority within one cycle:
  1. `reset`
  2. `load_alarma`
  3. `alarm_dis`
  4. `alarm_off`
  5. `snooze`
  6. trigger / timeout / snooze expiry
- For the time registers, `load_timp` has priority over `tick_sec`; that tick is dropped.
- Counter widths:
  - Ring counter: 8 bits.
  - Snooze counter: 10 bits.
  - All arithmetic is unsigned with no overflow beyond the stated wraps.

## Timing
- All outputs are registered.
- Effects of a load or tick sampled at posedge N are visible after posedge N.
- The setting block drives on negedge, so its pulses are stable for a half cycle before the sampling posedge.
- Pulses are assumed one cycle wide. A level held for k cycles is acted on every cycle: a repeated reload is harmless, and `tick_sec` held counts k seconds.
- `alarm_ring` rises in the same cycle as the trigger tick's time update, i.e. visible with HH:MM:00.
- Timeout: `alarm_ring` falls after the `RING_SECONDS`-th tick following the trigger.
- `load_err` is high for exactly one cycle per rejected load.
- Reset mid-ring or mid-snooze: next cycle `alarm_ring`=0, state DISARMED, time 00:00:00.

## Configuration
- Macro `CEAS_ALARMA_SNOOZE_EN`.
- Defined:
  - SNOOZE state, snooze counter and `snooze` input are active.
- Undefined:
  - No SNOOZE state or counter; `snooze` is ignored.
  - RINGING exits only by timeout, `alarm_off`, `alarm_dis`, `load_alarma` or reset.

## Test plan
- Rollover: `load_timp` 23:59, 60 ticks → 00:00:00; at tick 59 time reads 23:59:59.
- Load/tick collision: `load_timp` 10:20 together with `tick_sec` → 10:20:00, tick dropped; `ore_in`=24 → time unchanged, `load_err` pulses once.
- Alarm ring and timeout:
  - Setup: alarm 07:30, time 07:29, `RING_SECONDS`=60.
  - 60 ticks → `alarm_ring`=1 at 07:30:00.
  - 60 further ticks → `alarm_ring`=0, `alarm_armed`=1.
- Stop and disarm:
  - `alarm_off` during ringing → `alarm_ring`=0 next cycle, state ARMED.
  - `alarm_dis` → `alarm_armed`=0.
  - Loading time 07:30:00 does not ring.
- Snooze (macro defined, `SNOOZE_MIN`=5):
  - `snooze` while ringing → `alarm_ring`=0.
  - After 300 ticks → `alarm_ring`=1.
  - Without the macro, `snooze` has no effect.
- Reset mid-ring: `reset` while `alarm_ring`=1 → all outputs 0 next cycle.

Source files
------------

// File: rtl/ceas_alarma_if.sv
`default_nettype none
// ============================================================================
// Module      : ceas_alarma_if
// Description : Setting-path bundle between the setting block (master) and
//               the clock/alarm keeper (slave): hours/minutes value plus the
//               one-cycle load pulses for time and alarm.
// Revision    : 1.0 - initial release
// ============================================================================
interface ceas_alarma_if;
  logic [4:0] ore_in;
  logic [5:0] minute_in;
  logic       load_timp;
  logic       load_alarma;

  modport master (output ore_in, output minute_in, output load_timp, output load_alarma);
  modport slave  (input  ore_in, input  minute_in, input  load_timp, input  load_alarma);
endinterface
`default_nettype wire

// File: rtl/ceas_alarma.sv
`default_nettype none
// ============================================================================
// Module      : ceas_alarma
// Description : Keeps running time HH:MM:SS from a 1 Hz enable, stores the
//               alarm time and runs the alarm state machine driving the ring
//               output. Out-of-range loads are rejected with a load_err pulse.
//               Optional snooze support is enabled by defining the macro
//               CEAS_ALARMA_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ceas_alarma #(
  parameter int RING_SECONDS = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input  logic         clock,
  input  logic         reset,
  ceas_alarma_if.slave set_if,
  input  logic         tick_sec,
  input  logic         alarm_off,
  input  logic         alarm_dis,
  input  logic         snooze,
  output logic [4:0]   ore,
  output logic [5:0]   minute,
  output logic [5:0]   secunde,
  output logic [4:0]   alarm_ore,
  output logic [5:0]   alarm_min,
  output logic         alarm_armed,
  output logic         alarm_ring,
  output logic         load_err
);

  localparam logic [7:0] c_RING_TICKS   = 8'(RING_SECONDS);
  localparam logic [9:0] c_SNOOZE_TICKS = 10'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZE   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_ring_cnt;
  logic [7:0] w_ring_cnt_next;
  logic [7:0] w_ring_cnt_inc;

  logic       w_valid;
  logic       w_tick_time;
  logic       w_trigger;
  logic [5:0] w_sec_inc;
  logic [5:0] w_min_inc;
  logic [4:0] w_ore_inc;

`ifdef CEAS_ALARMA_SNOOZE_EN
  logic [9:0] r_snz_cnt;
  logic [9:0] w_snz_cnt_next;
`else
  logic       w_unused;
  assign w_unused = &{1'b0, snooze, c_SNOOZE_TICKS};
`endif

  // One shared range check serves both load pulses.
  assign w_valid     = (set_if.ore_in <= 5'd23) && (set_if.minute_in <= 6'd59);
  // A tick coinciding with a time load is dropped.
  assign w_tick_time = tick_sec && !set_if.load_timp;
  assign w_ring_cnt_inc = r_ring_cnt + 8'd1;

  // Time value one second ahead, with the HH:MM:SS carry chain.
  always_comb begin
    w_sec_inc = (secunde == 6'd59) ? 6'd0 : secunde + 6'd1;
    w_min_inc = minute;
    w_ore_inc = ore;
    if (secunde == 6'd59) begin
      w_min_inc = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
      if (minute == 6'd59) begin
        w_ore_inc = (ore == 5'd23) ? 5'd0 : ore + 5'd1;
      end
    end
  end

  // Only a tick landing on HH:MM:00 of the alarm time triggers, never a load.
  assign w_trigger = w_tick_time && (w_sec_inc == 6'd0) &&
                     (w_min_inc == alarm_min) && (w_ore_inc == alarm_ore);

  // Running time registers and the rejected-load flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      ore      <= 5'd0;
      minute   <= 6'd0;
      secunde  <= 6'd0;
      load_err <= 1'b0;
    end else begin
      load_err <= (set_if.load_timp || set_if.load_alarma) && !w_valid;
      if (set_if.load_timp) begin
        if (w_valid) begin
          ore     <= set_if.ore_in;
          minute  <= set_if.minute_in;
          secunde <= 6'd0;
        end
      end else if (tick_sec) begin
        ore     <= w_ore_inc;
        minute  <= w_min_inc;
        secunde <= w_sec_inc;
      end
    end
  end

  // Stored alarm time, updated only by an in-range alarm load.
  always_ff @(posedge clock) begin
    if (reset) begin
      alarm_ore <= 5'd0;
      alarm_min <= 6'd0;
    end else if (set_if.load_alarma && w_valid) begin
      alarm_ore <= set_if.ore_in;
      alarm_min <= set_if.minute_in;
    end
  end

  // Alarm state register; status outputs are registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_DISARMED;
      r_ring_cnt  <= 8'd0;
      alarm_armed <= 1'b0;
      alarm_ring  <= 1'b0;
`ifdef CEAS_ALARMA_SNOOZE_EN
      r_snz_cnt   <= 10'd0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_ring_cnt  <= w_ring_cnt_next;
      alarm_armed <= (w_state_next != ST_DISARMED);
      alarm_ring  <= (w_state_next == ST_RINGING);
`ifdef CEAS_ALARMA_SNOOZE_EN
      r_snz_cnt   <= w_snz_cnt_next;
`endif
    end
  end

  // Next-state logic; branch order encodes the command priority.
  always_comb begin
    w_state_next    = r_state;
    w_ring_cnt_next = r_ring_cnt;
`ifdef CEAS_ALARMA_SNOOZE_EN
    w_snz_cnt_next  = r_snz_cnt;
`endif
    if (set_if.load_alarma) begin
      // A rejected alarm load freezes the state machine for that cycle.
      if (w_valid) begin
        w_state_next    = ST_ARMED;
        w_ring_cnt_next = 8'd0;
`ifdef CEAS_ALARMA_SNOOZE_EN
        w_snz_cnt_next  = 10'd0;
`endif
      end
    end else if (alarm_dis) begin
      w_state_next = ST_DISARMED;
    end else if (alarm_off && (r_state != ST_DISARMED)) begin
      w_state_next = ST_ARMED;
`ifdef CEAS_ALARMA_SNOOZE_EN
    end else if (snooze && (r_state == ST_RINGING)) begin
      w_state_next   = ST_SNOOZE;
      w_snz_cnt_next = c_SNOOZE_TICKS;
`endif
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_trigger) begin
            w_state_next    = ST_RINGING;
            w_ring_cnt_next = 8'd0;
          end
        end
        ST_RINGING: begin
          if (tick_sec) begin
            w_ring_cnt_next = w_ring_cnt_inc;
            if (w_ring_cnt_inc == c_RING_TICKS) begin
              w_state_next = ST_ARMED;
            end
          end
        end
`ifdef CEAS_ALARMA_SNOOZE_EN
        ST_SNOOZE: begin
          if (tick_sec) begin
            w_snz_cnt_next = r_snz_cnt - 10'd1;
            if (r_snz_cnt == 10'd1) begin
              w_state_next    = ST_RINGING;
              w_ring_cnt_next = 8'd0;
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ceas_alarma.sv
`default_nettype none
// ============================================================================
// Module      : tb_ceas_alarma
// Description : Self-checking bench for ceas_alarma: directed scenarios with
//               constant expectations, then randomized traffic compared to a
//               seconds-of-day behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ceas_alarma;

  localparam int RING = 60;
  localparam int SMIN = 5;
`ifdef CEAS_ALARMA_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  localparam int M_DIS = 0, M_ARM = 1, M_RING = 2, M_SNZ = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick_sec = 1'b0, alarm_off = 1'b0, alarm_dis = 1'b0, snooze = 1'b0;
  logic [4:0] ore, alarm_ore;
  logic [5:0] minute, secunde, alarm_min;
  logic alarm_armed, alarm_ring, load_err;

  ceas_alarma_if bus ();

  ceas_alarma #(.RING_SECONDS(RING), .SNOOZE_MIN(SMIN)) dut (
    .clock(clock), .reset(reset), .set_if(bus),
    .tick_sec(tick_sec), .alarm_off(alarm_off), .alarm_dis(alarm_dis), .snooze(snooze),
    .ore(ore), .minute(minute), .secunde(secunde),
    .alarm_ore(alarm_ore), .alarm_min(alarm_min),
    .alarm_armed(alarm_armed), .alarm_ring(alarm_ring), .load_err(load_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: time as seconds of day, alarm as minutes of day.
  int m_secs = 0, m_alarm = 0, m_mode = M_DIS, m_rung = 0, m_snz = 0;
  bit m_err = 1'b0;

  task automatic model_step(input bit rst, input bit tk, input bit lt, input bit la,
                            input bit off, input bit dis, input bit sn,
                            input int oh, input int om);
    bit valid, trig;
    if (rst) begin
      m_secs = 0; m_alarm = 0; m_mode = M_DIS; m_rung = 0; m_snz = 0; m_err = 0;
    end else begin
      valid = (oh <= 23) && (om <= 59);
      m_err = (lt || la) && !valid;
      trig  = 1'b0;
      if (lt) begin
        if (valid) m_secs = oh * 3600 + om * 60;
      end else if (tk) begin
        m_secs = (m_secs + 1) % 86400;
        trig   = (m_secs == m_alarm * 60);
      end
      if (la) begin
        if (valid) begin
          m_alarm = oh * 60 + om; m_mode = M_ARM; m_rung = 0; m_snz = 0;
        end
      end else if (dis) m_mode = M_DIS;
      else if (off && m_mode != M_DIS) m_mode = M_ARM;
      else if (SNZ_EN && sn && m_mode == M_RING) begin
        m_mode = M_SNZ; m_snz = SMIN * 60;
      end else if (m_mode == M_ARM && trig) begin
        m_mode = M_RING; m_rung = 0;
      end else if (m_mode == M_RING && tk) begin
        m_rung++;
        if (m_rung == RING) m_mode = M_ARM;
      end else if (m_mode == M_SNZ && tk) begin
        m_snz--;
        if (m_snz == 0) begin m_mode = M_RING; m_rung = 0; end
      end
    end
  endtask

  // One clock cycle: inputs driven on negedge, sampled at posedge, released after.
  task automatic apply(input bit rst, input bit tk, input bit lt, input bit la,
                       input bit off, input bit dis, input bit sn,
                       input int oh, input int om);
    @(negedge clock);
    reset = rst; tick_sec = tk; alarm_off = off; alarm_dis = dis; snooze = sn;
    bus.load_timp = lt; bus.load_alarma = la;
    bus.ore_in = oh[4:0]; bus.minute_in = om[5:0];
    @(posedge clock);
    #1;
    reset = 1'b0; tick_sec = 1'b0; alarm_off = 1'b0; alarm_dis = 1'b0; snooze = 1'b0;
    bus.load_timp = 1'b0; bus.load_alarma = 1'b0;
    model_step(rst, tk, lt, la, off, dis, sn, oh, om);
  endtask

  task automatic idle();        apply(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic tick();        apply(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic load_time(input int h, input int m);  apply(0, 0, 1, 0, 0, 0, 0, h, m); endtask
  task automatic load_alarm(input int h, input int m); apply(0, 0, 0, 1, 0, 0, 0, h, m); endtask

  // Bring an armed 07:30 alarm to ringing: time 07:29, then 60 ticks.
  task automatic ring_up();
    load_time(7, 29);
    for (int i = 0; i < 60; i++) tick();
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({ore, minute, secunde} !== 17'd0) begin
      n_fail++; $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", ore, minute, secunde);
    end
    n_tests++;
    if ({alarm_ore, alarm_min, alarm_armed, alarm_ring, load_err} !== 14'd0) begin
      n_fail++; $display("FAIL reset_alarm got %0d:%0d armed=%b ring=%b err=%b want all 0",
                         alarm_ore, alarm_min, alarm_armed, alarm_ring, load_err);
    end
  endtask

  task automatic test_rollover();
    load_time(23, 59);
    for (int i = 0; i < 59; i++) tick();
    n_tests++;
    if ({ore, minute, secunde} !== {5'd23, 6'd59, 6'd59}) begin
      n_fail++; $display("FAIL rollover_59 got %0d:%0d:%0d want 23:59:59", ore, minute, secunde);
    end
    tick();
    n_tests++;
    if ({ore, minute, secunde} !== 17'd0) begin
      n_fail++; $display("FAIL rollover_wrap got %0d:%0d:%0d want 0:0:0", ore, minute, secunde);
    end
  endtask

  task automatic test_load_collision();
    tick(); tick();
    apply(0, 1, 1, 0, 0, 0, 0, 10, 20);
    n_tests++;
    if ({ore, minute, secunde} !== {5'd10, 6'd20, 6'd0}) begin
      n_fail++; $display("FAIL load_tick got %0d:%0d:%0d want 10:20:0", ore, minute, secunde);
    end
    load_time(24, 0);
    n_tests++;
    if ({ore, minute, secunde, load_err} !== {5'd10, 6'd20, 6'd0, 1'b1}) begin
      n_fail++; $display("FAIL load_bad got %0d:%0d:%0d err=%b want 10:20:0 err=1",
                         ore, minute, secunde, load_err);
    end
    idle();
    n_tests++;
    if (load_err !== 1'b0) begin
      n_fail++; $display("FAIL load_err_width got %b want 0", load_err);
    end
  endtask

  task automatic test_alarm_timeout();
    bit seen;
    load_alarm(7, 30);
    load_time(7, 29);
    n_tests++;
    if ({alarm_ore, alarm_min, alarm_armed, alarm_ring} !== {5'd7, 6'd30, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL alarm_load got %0d:%0d armed=%b ring=%b want 7:30 armed=1 ring=0",
                         alarm_ore, alarm_min, alarm_armed, alarm_ring);
    end
    seen = 1'b0;
    for (int i = 0; i < 59; i++) begin tick(); seen |= alarm_ring; end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL ring_early got ring=1 before 07:30:00 want 0");
    end
    tick();
    n_tests++;
    if ({alarm_ring, ore, minute, secunde} !== {1'b1, 5'd7, 6'd30, 6'd0}) begin
      n_fail++; $display("FAIL ring_start got ring=%b at %0d:%0d:%0d want ring=1 at 7:30:0",
                         alarm_ring, ore, minute, secunde);
    end
    seen = 1'b1;
    for (int i = 0; i < 59; i++) begin tick(); seen &= alarm_ring; end
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++; $display("FAIL ring_hold got ring dropped before tick 60 want held");
    end
    tick();
    n_tests++;
    if ({alarm_ring, alarm_armed} !== 2'b01) begin
      n_fail++; $display("FAIL ring_timeout got ring=%b armed=%b want ring=0 armed=1",
                         alarm_ring, alarm_armed);
    end
  endtask

  task automatic test_stop_disarm();
    ring_up();
    n_tests++;
    if (alarm_ring !== 1'b1) begin
      n_fail++; $display("FAIL stop_ring_up got ring=%b want 1", alarm_ring);
    end
    apply(0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_tests++;
    if ({alarm_ring, alarm_armed} !== 2'b01) begin
      n_fail++; $display("FAIL alarm_off got ring=%b armed=%b want ring=0 armed=1",
                         alarm_ring, alarm_armed);
    end
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
    n_tests++;
    if ({alarm_ring, alarm_armed} !== 2'b00) begin
      n_fail++; $display("FAIL alarm_dis got ring=%b armed=%b want 0 0", alarm_ring, alarm_armed);
    end
    load_alarm(7, 30);
    load_time(7, 30);
    idle(); tick();
    n_tests++;
    if ({alarm_ring, alarm_armed, minute, secunde} !== {1'b0, 1'b1, 6'd30, 6'd1}) begin
      n_fail++; $display("FAIL load_no_ring got ring=%b armed=%b min=%0d sec=%0d want 0 1 30 1",
                         alarm_ring, alarm_armed, minute, secunde);
    end
  endtask

  task automatic test_snooze();
    bit seen;
    load_alarm(7, 30);
    ring_up();
    apply(0, 0, 0, 0, 0, 0, 1, 0, 0);
    if (SNZ_EN) begin
      n_tests++;
      if ({alarm_ring, alarm_armed} !== 2'b01) begin
        n_fail++; $display("FAIL snooze_stop got ring=%b armed=%b want 0 1", alarm_ring, alarm_armed);
      end
      seen = 1'b0;
      for (int i = 0; i < SMIN * 60 - 1; i++) begin tick(); seen |= alarm_ring; end
      n_tests++;
      if (seen !== 1'b0) begin
        n_fail++; $display("FAIL snooze_early got ring=1 before snooze end want 0");
      end
      tick();
      n_tests++;
      if (alarm_ring !== 1'b1) begin
        n_fail++; $display("FAIL snooze_end got ring=%b want 1", alarm_ring);
      end
    end else begin
      n_tests++;
      if ({alarm_ring, alarm_armed} !== 2'b11) begin
        n_fail++; $display("FAIL snooze_ignored got ring=%b armed=%b want 1 1", alarm_ring, alarm_armed);
      end
    end
  endtask

  task automatic test_reset_midring();
    load_alarm(7, 30);
    ring_up();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({ore, minute, secunde, alarm_ore, alarm_min, alarm_armed, alarm_ring, load_err} !== 31'd0) begin
      n_fail++; $display("FAIL reset_midring got %0d:%0d:%0d alarm %0d:%0d armed=%b ring=%b want all 0",
                         ore, minute, secunde, alarm_ore, alarm_min, alarm_armed, alarm_ring);
    end
  endtask

  task automatic test_random();
    logic [30:0] exp_v, got_v;
    int oh, om, near;
    bit rst, tk, lt, la, off, dis, sn;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 999) < 3);
      tk  = $urandom_range(0, 1);
      lt  = ($urandom_range(0, 99) < 1);
      la  = ($urandom_range(0, 99) < 1);
      off = ($urandom_range(0, 99) < 1);
      dis = ($urandom_range(0, 199) < 1);
      sn  = ($urandom_range(0, 99) < 2);
      oh  = $urandom_range(0, 25);
      om  = $urandom_range(0, 63);
      if (la && $urandom_range(0, 1)) begin
        near = (m_secs / 60 + 1) % 1440;
        oh = near / 60; om = near % 60;
      end
      apply(rst, tk, lt, la, off, dis, sn, oh, om);
      exp_v = {5'(m_secs / 3600), 6'((m_secs / 60) % 60), 6'(m_secs % 60),
               5'(m_alarm / 60), 6'(m_alarm % 60),
               (m_mode != M_DIS), (m_mode == M_RING), m_err};
      got_v = {ore, minute, secunde, alarm_ore, alarm_min, alarm_armed, alarm_ring, load_err};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL random cycle %0d got %h want %h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    bus.ore_in = 5'd0; bus.minute_in = 6'd0;
    bus.load_timp = 1'b0; bus.load_alarma = 1'b0;
    test_reset();
    test_rollover();
    test_load_collision();
    test_alarm_timeout();
    test_stop_disarm();
    test_snooze();
    test_reset_midring();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
